countdown_timer: RTL
====================

# countdown_timer

Loadable MM:SS BCD countdown timer: the down-counting counterpart to the lab's clock-enabled up counters. It holds a 4-digit BCD value and decrements it by one second on each `ce` tick while running, with correct per-digit borrows (seconds roll 00→59, minutes 0→9). It issues a one-cycle `expired` pulse on reaching zero. It sits beside the time-of-day/alarm counters on the iCEstick and is driven by the same 1 Hz enable tick.

## Interface
- `AUTO_RELOAD`, default 0: when 1, expiry reloads the last valid load value and keeps running instead of stopping.
- `clk` in 1: system clock. All state changes on the rising edge.
- `rst` in 1: reset, asynchronous, active-high.
- `d` in 16: load value `{m1,m0,s1,s0}`, 4 bits BCD per digit.
- `ld` in 1: load `d` into the counter.
- `start` in 1: begin or resume counting.
- `stop` in 1: pause counting.
- `ce` in 1: one-cycle tick enable (1 Hz); one decrement per asserted cycle while running.
- `q` out 16: current count `{m1,m0,s1,s0}`, registered.
- `running` out 1: high in state RUN.
- `zero` out 1: combinational, `q == 16'h0000`.
- `expired` out 1: registered, one-cycle pulse on expiry.
- `err` out 1: registered, one-cycle pulse on a rejected load.

## Operation
- **States:** IDLE, RUN, PAUSE. `running` = (state == RUN).
- **Reset:** async assert forces state=IDLE, `q`=0000, reload register=0000, `expired`=0, `err`=0.
- **Event priority per edge:** `ld` > `stop` > `start` > `ce`. Only the highest-priority applicable event acts.
- **Load validity:** a load is valid iff every digit ≤ 9 and `s1` ≤ 5.
- **Valid `ld` (any state):**
  - `q` ← `d` and reload register ← `d`.
  - State → IDLE, which also stops a running timer.
- **Invalid `ld`:** `q`, reload register and state are unchanged. `err` pulses.
- **`stop`:** in RUN, state → PAUSE with no decrement that cycle. Ignored in IDLE/PAUSE.
- **`start`:**
  - In IDLE or PAUSE with `q` ≠ 0: state → RUN, no decrement that cycle.
  - With `q` = 0: ignored.
  - In RUN: no effect, and `ce` in the same cycle still decrements.
- **`ce` in RUN, `q` > 0001:** decrement with borrow chain.
  - `s0`: 0→9 with borrow, else −1.
  - `s1`: on borrow, 0→5 with borrow, else −1.
  - `m0`: on borrow, 0→9 with borrow, else −1.
  - `m1`: on borrow, −1.
- **`ce` in RUN, `q` = 0001 (expiry):** `expired` pulses.
  - AUTO_RELOAD=0: `q` → 0000, state → IDLE.
  - AUTO_RELOAD=1: `q` → reload register and state stays RUN. If the reload register is 0000, `q` → 0000 and state → IDLE.
- **`ce` outside RUN:** ignored.

## Timing
- Single-cycle latency: an event sampled at edge N is reflected in `q`/state/`running` after edge N.
- `expired` and `err` are high for exactly the one cycle following the causing edge. Both deassert on the next edge unless re-caused.
- `zero` follows `q` combinationally with no added latency.
- Back-to-back `ce` on consecutive cycles must each decrement. No minimum tick spacing.
- `rst` mid-count: immediate (asynchronous) return to reset values, with no `expired` pulse. Deassertion is assumed synchronized externally.
- `q` never holds a non-BCD value or `s1` > 5.

## Test plan
- **Reset:** drive `ld`=1 with `d`=1234, then assert `rst` between edges → `q`=0000, `running`=0, `expired`=0, `err`=0 immediately, without waiting for an edge.
- **Borrow chain:** load 1000, start, one `ce` → `q`=0959. Load 0100, start, `ce` → `q`=0059.
- **Expiry (AUTO_RELOAD=0):** load 0003, start, 3 `ce` → `q` steps 0002, 0001, 0000. `expired` is high for exactly one cycle after the third tick. `running`=0. A further `start` is ignored.
- **Priority:** in RUN with `q`=0030, assert `stop` and `ce` together → PAUSE, `q`=0030. Assert `start` and `ce` together → RUN, `q`=0030. Assert `ld`(0045) and `ce` together → `q`=0045, IDLE.
- **Invalid load:** with `q`=0120, load 0070 (`s1`=7) → `err` is a one-cycle pulse and `q` stays 0120. Load 00A0 → same result.
- **AUTO_RELOAD=1:** load 0002, start, 4 `ce` → `q` sequence 0001, 0002, 0001, 0002. `expired` pulses after ticks 2 and 4. `running` stays 1 throughout.

Source files
------------

// File: rtl/countdown_timer.sv
// countdown_timer
//   Loadable MM:SS BCD countdown timer. Counts down one second per `ce` tick
//   while running, borrowing across digits (seconds wrap 00->59, minutes
//   digits wrap 0->9), and pulses `expired` for one cycle on reaching zero.
//
// Parameters
//   AUTO_RELOAD : 1 = on expiry, reload the last valid load value and keep
//                 running; 0 = stop at 0000.
// Ports
//   clk     : system clock, rising edge
//   rst     : asynchronous active-high reset
//   d       : load value {m1,m0,s1,s0}, BCD
//   ld      : load d (highest priority event)
//   start   : begin/resume counting
//   stop    : pause counting
//   ce      : 1 Hz tick enable, one decrement per asserted cycle in RUN
//   q       : current count {m1,m0,s1,s0}, registered
//   running : high while in RUN
//   zero    : combinational, q == 0000
//   expired : one-cycle registered pulse on expiry
//   err     : one-cycle registered pulse on a rejected load
module countdown_timer #(
    parameter bit AUTO_RELOAD = 1'b0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] d,
    input  logic        ld,
    input  logic        start,
    input  logic        stop,
    input  logic        ce,
    output logic [15:0] q,
    output logic        running,
    output logic        zero,
    output logic        expired,
    output logic        err
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2
    } state_t;

    state_t      state_reg, state_next;
    logic [15:0] q_reg, q_next;
    logic [15:0] reload_reg, reload_next;
    logic        expired_reg, expired_next;
    logic        err_reg, err_next;

    logic [15:0] q_dec;      // q_reg minus one second
    logic [3:0]  borrow;     // borrow into each digit; s0 always decrements
    logic [3:0]  digit_ok;   // per-digit range check of the load value
    logic        ld_valid;

    assign borrow[0] = 1'b1;

    // Digit 1 (tens of seconds) wraps at 5, all others at 9. The same limit
    // serves both the borrow chain and the load range check.
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_digit
            localparam logic [3:0] DIGIT_MAX = (gi == 1) ? 4'd5 : 4'd9;
            logic [3:0] digit;

            assign digit        = q_reg[4*gi +: 4];
            assign digit_ok[gi] = (d[4*gi +: 4] <= DIGIT_MAX);
            assign q_dec[4*gi +: 4] = !borrow[gi]     ? digit :
                                      (digit == 4'd0) ? DIGIT_MAX :
                                                        digit - 4'd1;
            if (gi < 3) begin : g_borrow
                assign borrow[gi+1] = borrow[gi] & (digit == 4'd0);
            end
        end
    endgenerate

    assign ld_valid = &digit_ok;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg   <= IDLE;
            q_reg       <= 16'h0000;
            reload_reg  <= 16'h0000;
            expired_reg <= 1'b0;
            err_reg     <= 1'b0;
        end else begin
            state_reg   <= state_next;
            q_reg       <= q_next;
            reload_reg  <= reload_next;
            expired_reg <= expired_next;
            err_reg     <= err_next;
        end
    end

    // Events are tested in priority order; an event that does not apply in
    // the current state falls through so a lower-priority one can act
    // (e.g. start in RUN lets the same-cycle ce decrement).
    always_comb begin
        state_next   = state_reg;
        q_next       = q_reg;
        reload_next  = reload_reg;
        expired_next = 1'b0;
        err_next     = 1'b0;

        if (ld) begin
            if (ld_valid) begin
                q_next      = d;
                reload_next = d;
                state_next  = IDLE;
            end else begin
                err_next = 1'b1;
            end
        end else if (stop && state_reg == RUN) begin
            state_next = PAUSE;
        end else if (start && state_reg != RUN && q_reg != 16'h0000) begin
            state_next = RUN;
        end else if (ce && state_reg == RUN) begin
            if (q_reg == 16'h0001) begin
                expired_next = 1'b1;
                // A zero reload value would restart at 0000, so stop instead.
                if (AUTO_RELOAD && reload_reg != 16'h0000) begin
                    q_next = reload_reg;
                end else begin
                    q_next     = 16'h0000;
                    state_next = IDLE;
                end
            end else begin
                q_next = q_dec;
            end
        end
    end

    assign q       = q_reg;
    assign running = (state_reg == RUN);
    assign zero    = (q_reg == 16'h0000);
    assign expired = expired_reg;
    assign err     = err_reg;

endmodule
